// File: rtl/ram_dp_be_pkg.sv
// rtl/ram_dp_be_pkg.sv - shared defaults and helpers for the byte-enable dual-port RAM
// RAM_DP_FWD_EN: defined -> a same-word write/read collision returns the merged word (write-first); undefined -> pre-write word (read-first).
package ram_dp_be_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 32;
    localparam int DEFAULT_DEPTH      = 4096;
    localparam int DEFAULT_RD_LATENCY = 1;

    localparam int BE_WIDTH    = DEFAULT_DATA_WIDTH / 8;
    localparam int BYTE_OFFSET = $clog2(BE_WIDTH);

    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int byte_offset(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/ram_dp_be_if.sv
// rtl/ram_dp_be_if.sv - write/read port bundle between the LSU (master) and the RAM (slave)
interface ram_dp_be_if
    import ram_dp_be_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);
    logic                    wr_en_i;
    logic [ADDR_WIDTH-1:0]   wr_addr_i;
    logic [DATA_WIDTH-1:0]   wr_data_i;
    logic [DATA_WIDTH/8-1:0] wr_be_i;
    logic                    rd_req_i;
    logic [ADDR_WIDTH-1:0]   rd_addr_i;
    logic [DATA_WIDTH-1:0]   rd_data_o;
    logic                    rd_vld_o;
    logic                    rd_err_o;
    logic                    wr_err_o;

    modport master (
        output wr_en_i, wr_addr_i, wr_data_i, wr_be_i, rd_req_i, rd_addr_i,
        input  rd_data_o, rd_vld_o, rd_err_o, wr_err_o
    );

    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i, wr_be_i, rd_req_i, rd_addr_i,
        output rd_data_o, rd_vld_o, rd_err_o, wr_err_o
    );

endinterface

// File: rtl/ram_be_merge.sv
// rtl/ram_be_merge.sv - combinational byte-lane merge of an old word and a new word under a byte mask
module ram_be_merge
    import ram_dp_be_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0]   old_data,
    input  logic [DATA_WIDTH-1:0]   new_data,
    input  logic [DATA_WIDTH/8-1:0] be,
    output logic [DATA_WIDTH-1:0]   merged
);
    localparam int BE_W = be_width(DATA_WIDTH);

    always_comb begin
        merged = old_data;
        for (int k = 0; k < BE_W; k++) begin
            if (be[k]) begin
                merged[8*k +: 8] = new_data[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/ram_dp_be.sv
// rtl/ram_dp_be.sv - simple dual-port data RAM with byte enables, 1/2-cycle read latency, range checking
// RAM_DP_FWD_EN selects write-first collision behaviour; undefined gives read-first.
module ram_dp_be
    import ram_dp_be_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int RD_LATENCY = DEFAULT_RD_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    ram_dp_be_if.slave  bus
);
    localparam int OFFS   = byte_offset(DATA_WIDTH);
    localparam int IDX_W  = ADDR_WIDTH - OFFS;
    localparam int MEM_AW = $clog2(DEPTH);

    logic [IDX_W-1:0]      wr_word;
    logic [IDX_W-1:0]      rd_word;
    logic [MEM_AW-1:0]     wr_idx;
    logic [MEM_AW-1:0]     rd_idx;
    logic                  wr_oor;
    logic                  rd_oor;
    logic                  wr_do;
    logic                  wr_err_q;
    logic [DATA_WIDTH-1:0] wr_old;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic [DATA_WIDTH-1:0] rd_old;
    logic [DATA_WIDTH-1:0] rd_fetch;
    logic                  s1_vld;
    logic                  s1_err;
    logic [DATA_WIDTH-1:0] s1_data;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign wr_word = bus.wr_addr_i[ADDR_WIDTH-1:OFFS];
    assign rd_word = bus.rd_addr_i[ADDR_WIDTH-1:OFFS];
    assign wr_idx  = wr_word[MEM_AW-1:0];
    assign rd_idx  = rd_word[MEM_AW-1:0];

    // DEPTH is a power of two, so out-of-range means any word-index bit above the array is set.
    generate
        if (IDX_W > MEM_AW) begin : g_range
            assign wr_oor = |wr_word[IDX_W-1:MEM_AW];
            assign rd_oor = |rd_word[IDX_W-1:MEM_AW];
        end else begin : g_full
            assign wr_oor = 1'b0;
            assign rd_oor = 1'b0;
        end
        if (OFFS > 0) begin : g_lane_bits
            logic unused_addr_bits;
            assign unused_addr_bits = ^{bus.wr_addr_i[OFFS-1:0], bus.rd_addr_i[OFFS-1:0]};
        end
    endgenerate

    assign wr_do  = bus.wr_en_i && !wr_oor && (|bus.wr_be_i);
    assign wr_old = mem[wr_idx];
    assign rd_old = mem[rd_idx];

    ram_be_merge #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_merge (
        .old_data (wr_old),
        .new_data (bus.wr_data_i),
        .be       (bus.wr_be_i),
        .merged   (wr_merged)
    );

    // Array contents are deliberately not reset; writes are only held off while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && wr_do) begin
            mem[wr_idx] <= wr_merged;
        end
    end

`ifdef RAM_DP_FWD_EN
    logic collide;
    assign collide  = wr_do && bus.rd_req_i && !rd_oor && (wr_idx == rd_idx);
    assign rd_fetch = collide ? wr_merged : rd_old;
`else
    assign rd_fetch = rd_old;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_err  <= 1'b0;
            s1_data <= '0;
        end else begin
            s1_vld <= bus.rd_req_i;
            if (bus.rd_req_i) begin
                s1_data <= rd_oor ? '0 : rd_fetch;
                s1_err  <= rd_oor;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= bus.wr_en_i && (|bus.wr_be_i) && wr_oor;
        end
    end

    assign bus.wr_err_o = wr_err_q;

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                  s2_vld;
            logic                  s2_err;
            logic [DATA_WIDTH-1:0] s2_data;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_vld  <= 1'b0;
                    s2_err  <= 1'b0;
                    s2_data <= '0;
                end else begin
                    s2_vld <= s1_vld;
                    if (s1_vld) begin
                        s2_data <= s1_data;
                        s2_err  <= s1_err;
                    end
                end
            end

            assign bus.rd_vld_o  = s2_vld;
            assign bus.rd_err_o  = s2_err;
            assign bus.rd_data_o = s2_data;
        end else begin : g_lat1
            assign bus.rd_vld_o  = s1_vld;
            assign bus.rd_err_o  = s1_err;
            assign bus.rd_data_o = s1_data;
        end
    endgenerate

endmodule

// File: tb/tb_ram_dp_be.sv
// tb/tb_ram_dp_be.sv - bench for ram_dp_be: latency-1 and latency-2 instances, DEPTH=16, vector table plus randomized model check
module tb_ram_dp_be;
    import ram_dp_be_pkg::*;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int DEP = 16;

`ifdef RAM_DP_FWD_EN
    localparam logic [31:0] COLL_EXP = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] COLL_EXP = 32'h0000_0000;
`endif

    logic clk = 1'b0;
    logic rst;

    ram_dp_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
    ram_dp_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

    assign bus2.wr_en_i   = bus1.wr_en_i;
    assign bus2.wr_addr_i = bus1.wr_addr_i;
    assign bus2.wr_data_i = bus1.wr_data_i;
    assign bus2.wr_be_i   = bus1.wr_be_i;
    assign bus2.rd_req_i  = bus1.rd_req_i;
    assign bus2.rd_addr_i = bus1.rd_addr_i;

    ram_dp_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .RD_LATENCY(1)) u_lat1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    ram_dp_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .RD_LATENCY(2)) u_lat2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] d;
        logic        e;
    } rsp_t;

    typedef struct {
        logic        r;
        logic        we;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        re;
        logic [31:0] ra;
        logic        ev;
        logic [31:0] ed;
        logic        ee;
        logic        ewe;
    } vec_t;

    int          checks = 0;
    int          passes = 0;
    int          cyc    = 0;
    logic [31:0] mm [DEP];
    rsp_t        q1 [$];
    rsp_t        q2 [$];
    logic [31:0] ld1, ld2;
    logic        le1, le2;
    logic        exp_wrerr;
    vec_t        tbl [14];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, got, exp);
        else passes++;
    endtask

    function automatic logic oor(input logic [31:0] a);
        return (a >> 2) >= 32'(DEP);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = nw[8*k +: 8];
        return r;
    endfunction

    // Reference model: memory array plus a queue of due responses per instance.
    task automatic model_edge();
        logic [31:0] rd;
        logic        e;
        cyc++;
        if (rst) begin
            q1.delete();
            q2.delete();
            ld1 = '0; le1 = 1'b0; ld2 = '0; le2 = 1'b0;
            exp_wrerr = 1'b0;
            return;
        end
        if (bus1.rd_req_i) begin
            if (oor(bus1.rd_addr_i)) begin
                rd = '0;
                e  = 1'b1;
            end else begin
                rd = mm[bus1.rd_addr_i[5:2]];
                e  = 1'b0;
`ifdef RAM_DP_FWD_EN
                if (bus1.wr_en_i && !oor(bus1.wr_addr_i) && bus1.wr_addr_i[5:2] == bus1.rd_addr_i[5:2])
                    rd = merge(rd, bus1.wr_data_i, bus1.wr_be_i);
`endif
            end
            q1.push_back('{due: cyc,     d: rd, e: e});
            q2.push_back('{due: cyc + 1, d: rd, e: e});
        end
        exp_wrerr = bus1.wr_en_i && (|bus1.wr_be_i) && oor(bus1.wr_addr_i);
        if (bus1.wr_en_i && !oor(bus1.wr_addr_i))
            mm[bus1.wr_addr_i[5:2]] = merge(mm[bus1.wr_addr_i[5:2]], bus1.wr_data_i, bus1.wr_be_i);
    endtask

    task automatic check_model();
        logic v1, v2;
        v1 = 1'b0;
        v2 = 1'b0;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            v1 = 1'b1; ld1 = q1[0].d; le1 = q1[0].e; void'(q1.pop_front());
        end
        if (q2.size() > 0 && q2[0].due == cyc) begin
            v2 = 1'b1; ld2 = q2[0].d; le2 = q2[0].e; void'(q2.pop_front());
        end
        chk("l1_vld",   32'(bus1.rd_vld_o), 32'(v1));
        chk("l1_data",  bus1.rd_data_o,     ld1);
        chk("l1_err",   32'(bus1.rd_err_o), 32'(le1));
        chk("l1_wrerr", 32'(bus1.wr_err_o), 32'(exp_wrerr));
        chk("l2_vld",   32'(bus2.rd_vld_o), 32'(v2));
        chk("l2_data",  bus2.rd_data_o,     ld2);
        chk("l2_err",   32'(bus2.rd_err_o), 32'(le2));
        chk("l2_wrerr", 32'(bus2.wr_err_o), 32'(exp_wrerr));
    endtask

    task automatic drive(input logic r, input logic we, input logic [31:0] wa, input logic [31:0] wd,
                         input logic [3:0] be, input logic re, input logic [31:0] ra);
        rst            = r;
        bus1.wr_en_i   = we;
        bus1.wr_addr_i = wa;
        bus1.wr_data_i = wd;
        bus1.wr_be_i   = be;
        bus1.rd_req_i  = re;
        bus1.rd_addr_i = ra;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] be,
                                input logic re, input logic [31:0] ra,
                                input logic ev, input logic [31:0] ed, input logic ee, input logic ewe);
        vec_t v;
        v = '{r: 1'b0, we: we, wa: wa, wd: wd, be: be, re: re, ra: ra, ev: ev, ed: ed, ee: ee, ewe: ewe};
        return v;
    endfunction

    initial begin
        rst = 1'b1;
        bus1.wr_en_i = 1'b0; bus1.wr_addr_i = '0; bus1.wr_data_i = '0;
        bus1.wr_be_i = '0;   bus1.rd_req_i  = 1'b0; bus1.rd_addr_i = '0;

        // Reset held with random traffic: every output stays 0.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'($urandom), $urandom, $urandom, 4'($urandom), 1'($urandom), $urandom);
            chk("rst_l1_out", {bus1.rd_data_o[30:0] | {30'b0, bus1.rd_vld_o}, bus1.rd_err_o | bus1.wr_err_o}, 32'h0);
            chk("rst_l2_out", {bus2.rd_data_o[30:0] | {30'b0, bus2.rd_vld_o}, bus2.rd_err_o | bus2.wr_err_o}, 32'h0);
        end

        for (int i = 0; i < DEP; i++)
            drive(1'b0, 1'b1, 32'(i * 4), 32'hA500_0000 | 32'(i), 4'hF, 1'b0, '0);

        // Contents survive a reset; one read after release gives one pulse.
        drive(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 32'h4);
        chk("post_rst_vld",  32'(bus1.rd_vld_o), 32'h1);
        chk("post_rst_data", bus1.rd_data_o, 32'hA500_0001);
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
        chk("post_rst_once", 32'(bus1.rd_vld_o), 32'h0);

        tbl[0]  = mk(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0,     0, 32'hA5000001, 0, 0);
        tbl[1]  = mk(0, 0,      0,            4'h0, 1, 32'h10, 1, 32'hDEADBEEF, 0, 0);
        tbl[2]  = mk(1, 32'h20, 32'h11223344, 4'hF, 0, 0,     0, 32'hDEADBEEF, 0, 0);
        tbl[3]  = mk(1, 32'h20, 32'hAABBCCDD, 4'h5, 0, 0,     0, 32'hDEADBEEF, 0, 0);
        tbl[4]  = mk(0, 0,      0,            4'h0, 1, 32'h20, 1, 32'h11BB33DD, 0, 0);
        tbl[5]  = mk(1, 32'h30, 32'h00000000, 4'hF, 0, 0,     0, 32'h11BB33DD, 0, 0);
        tbl[6]  = mk(1, 32'h30, 32'hFFFFFFFF, 4'hF, 1, 32'h30, 1, COLL_EXP,     0, 0);
        tbl[7]  = mk(0, 0,      0,            4'h0, 1, 32'h30, 1, 32'hFFFFFFFF, 0, 0);
        tbl[8]  = mk(1, 32'h40, 32'h12345678, 4'hF, 0, 0,     0, 32'hFFFFFFFF, 0, 1);
        tbl[9]  = mk(1, 32'h10, 32'h00000000, 4'h0, 0, 0,     0, 32'hFFFFFFFF, 0, 0);
        tbl[10] = mk(0, 0,      0,            4'h0, 1, 32'h40, 1, 32'h00000000, 1, 0);
        tbl[11] = mk(0, 0,      0,            4'h0, 1, 32'h00, 1, 32'hA5000000, 0, 0);
        tbl[12] = mk(0, 0,      0,            4'h0, 1, 32'h10, 1, 32'hDEADBEEF, 0, 0);
        tbl[13] = mk(0, 0,      0,            4'h0, 0, 0,     0, 32'hDEADBEEF, 0, 0);

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].r, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].be, tbl[i].re, tbl[i].ra);
            chk($sformatf("tbl%0d_vld", i),   32'(bus1.rd_vld_o), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_data", i),  bus1.rd_data_o,     tbl[i].ed);
            chk($sformatf("tbl%0d_err", i),   32'(bus1.rd_err_o), 32'(tbl[i].ee));
            chk($sformatf("tbl%0d_wrerr", i), 32'(bus1.wr_err_o), 32'(tbl[i].ewe));
        end

        // Latency-2 back-to-back reads.
        drive(0, 0, '0, '0, '0, 1, 32'h0);
        chk("l2_b2b_0_vld", 32'(bus2.rd_vld_o), 32'h0);
        drive(0, 0, '0, '0, '0, 1, 32'h4);
        chk("l2_b2b_1_vld", 32'(bus2.rd_vld_o), 32'h1);
        chk("l2_b2b_1_dat", bus2.rd_data_o, 32'hA500_0000);
        drive(0, 0, '0, '0, '0, 1, 32'h8);
        chk("l2_b2b_2_vld", 32'(bus2.rd_vld_o), 32'h1);
        chk("l2_b2b_2_dat", bus2.rd_data_o, 32'hA500_0001);
        drive(0, 0, '0, '0, '0, 0, '0);
        chk("l2_b2b_3_vld", 32'(bus2.rd_vld_o), 32'h1);
        chk("l2_b2b_3_dat", bus2.rd_data_o, 32'hA500_0002);
        drive(0, 0, '0, '0, '0, 0, '0);
        chk("l2_b2b_4_vld", 32'(bus2.rd_vld_o), 32'h0);
        chk("l2_b2b_4_dat", bus2.rd_data_o, 32'hA500_0002);

        // Reset while a latency-2 read is in flight.
        drive(0, 0, '0, '0, '0, 1, 32'h4);
        drive(1, 0, '0, '0, '0, 0, '0);
        chk("midrst_l2_vld_a", 32'(bus2.rd_vld_o), 32'h0);
        drive(0, 0, '0, '0, '0, 0, '0);
        chk("midrst_l2_vld_b", 32'(bus2.rd_vld_o), 32'h0);

        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 39) == 0), 1'($urandom),
                  32'(($urandom_range(0, 21) << 2) | $urandom_range(0, 3)), $urandom, 4'($urandom),
                  1'($urandom),
                  32'(($urandom_range(0, 21) << 2) | $urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
